imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Groups the two data paths of the instruction-memory loader:
//   byte stream : byte_valid, byte_data (from source), byte_ready (to source)
//   SRAM init   : init_en, init_addr, init_data (to the SoC init port)
// Modports:
//   slave  - the loader itself (consumes bytes, drives the SRAM init port)
//   master - the environment (byte source and SRAM init sink)
// ---------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              init_en;
    logic [ADDR_W-1:0] init_addr;
    logic [31:0]       init_data;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, init_en, init_addr, init_data
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, init_en, init_addr, init_data
    );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Receives a little-endian byte stream, assembles 32-bit words and writes
// them into the instruction SRAM through the SoC init port, starting at
// BASE_ADDR and wrapping modulo 2^ADDR_W.
// Ports:
//   clk       - sole clock, rising edge
//   reset     - asynchronous, active-low
//   start     - one-cycle load request (honoured only when idle)
//   load_len  - number of words, legal range 1..2^ADDR_W
//   abort     - cancel the load in progress
//   bus       - byte stream + SRAM init port (imem_loader_if.slave)
//   busy      - load in progress
//   done      - level, set after a complete load until the next accepted start
//   err       - one-cycle pulse on an illegal start or an abort
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              abort,
    imem_loader_if.slave      bus,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE} state_t;

    // Largest legal length is 2^ADDR_W, i.e. only the top bit of load_len set.
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   words_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [1:0]        byte_cnt;
    // Only bytes 0..2 are buffered; byte 3 goes straight into init_data.
    logic [23:0]       asm_r;
    logic [ADDR_W:0]   words_next;

    assign bus.byte_ready = (state == RECV);
    assign words_next     = words_r + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            len_r         <= '0;
            words_r       <= '0;
            ptr_r         <= BASE_ADDR;
            byte_cnt      <= '0;
            asm_r         <= '0;
            bus.init_en   <= 1'b0;
            bus.init_addr <= BASE_ADDR;
            bus.init_data <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    // abort has priority over a simultaneous start
                    if (start && !abort) begin
                        if (load_len != '0 && load_len <= MAX_LEN) begin
                            state    <= RECV;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            len_r    <= load_len;
                            ptr_r    <= BASE_ADDR;
                            byte_cnt <= '0;
                            words_r  <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                RECV: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (bus.byte_valid) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        case (byte_cnt)
                            2'd0: asm_r[7:0]   <= bus.byte_data;
                            2'd1: asm_r[15:8]  <= bus.byte_data;
                            2'd2: asm_r[23:16] <= bus.byte_data;
                            2'd3: begin
                                state         <= WRITE;
                                bus.init_en   <= 1'b1;
                                bus.init_addr <= ptr_r;
                                bus.init_data <= {bus.byte_data, asm_r};
                            end
                        endcase
                    end
                end

                WRITE: begin
                    // The write strobe is already on the bus this cycle, so an
                    // abort here still lets the current word land.
                    bus.init_en <= 1'b0;
                    ptr_r       <= ptr_r + 1'b1;
                    words_r     <= words_next;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (words_next == len_r) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= RECV;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
